// File: rtl/bus65_initiator_if.sv
// 65C816-style bus pins between the bus-cycle initiator (master) and the
// memory-map responders: address decode, ROM, SRAM controller, ACIA (slave).
interface bus65_initiator_if;
  logic        phi2;
  logic [15:0] ab;
  logic [7:0]  db_o;
  logic        db_oe;
  logic [7:0]  db_i;
  logic        rwb;
  logic        vpa;
  logic        vda;
  logic        rdy;

  modport master (output phi2, ab, db_o, db_oe, rwb, vpa, vda, input db_i, rdy);
  modport slave  (input phi2, ab, db_o, db_oe, rwb, vpa, vda, output db_i, rdy);
endinterface

// File: rtl/bus65_initiator.sv
// Bus-cycle initiator: turns valid/ready requests into 65C816-style PHI2 bus
// cycles with bank/data multiplexing and RDY wait states; one-clk response pulse.
module bus65_initiator #(
  parameter int PHI_LO = 2,
  parameter int PHI_HI = 2
) (
  input  logic              clk,
  input  logic              resb,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [23:0]       req_addr,
  input  logic              req_rwb,
  input  logic [7:0]        req_wdata,
  input  logic              req_vpa,
  input  logic              req_vda,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              busy,
  bus65_initiator_if.master bus
);

  localparam int P  = PHI_LO + PHI_HI;
  localparam int CW = $clog2(P);
  localparam logic [CW-1:0] PH_LAST = CW'(P - 1);
  localparam logic [CW-1:0] PH_RISE = CW'(PHI_LO);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WAIT} state_t;

  typedef struct packed {
    logic [23:0] addr;
    logic        rwb;
    logic [7:0]  wdata;
    logic        vpa;
    logic        vda;
  } req_t;

  state_t        state, state_nxt;
  logic [CW-1:0] ph_cnt, ph_nxt;
  logic          boundary, phi2_rise;
  logic          accept, load, complete;
  logic          slot_full, slot_full_nxt;
  req_t          slot, cyc, cyc_nxt, req_in;

  assign req_in    = {req_addr, req_rwb, req_wdata, req_vpa, req_vda};
  assign accept    = req_valid && req_ready;
  assign boundary  = (ph_cnt == PH_LAST);
  assign ph_nxt    = boundary ? '0 : ph_cnt + CW'(1);
  assign phi2_rise = (ph_nxt == PH_RISE);
  assign busy      = (state != S_IDLE) || slot_full;

  // At a boundary a stalled cycle repeats; otherwise the slot (if full) starts.
  always_comb begin
    // NOTE: defaults first so no branch leaves a signal unassigned (no latches).
    state_nxt     = state;
    load          = 1'b0;
    complete      = 1'b0;
    cyc_nxt       = cyc;
    if (boundary) begin
      if (state != S_IDLE && !bus.rdy) begin
        state_nxt = S_WAIT;
      end else begin
        complete = (state != S_IDLE);
        if (slot_full) begin
          load      = 1'b1;
          cyc_nxt   = slot;
          state_nxt = S_ACTIVE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
    end
    slot_full_nxt = (slot_full && !load) || accept;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!resb) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resb) begin
      ph_cnt    <= '0;
      bus.phi2  <= 1'b0;
      slot_full <= 1'b0;
      slot      <= '0;
      cyc       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bus.ab    <= '0;
      bus.db_o  <= '0;
      bus.db_oe <= 1'b0;
      bus.rwb   <= 1'b1;
      bus.vpa   <= 1'b0;
      bus.vda   <= 1'b0;
    end else begin
      ph_cnt    <= ph_nxt;
      bus.phi2  <= (ph_nxt >= PH_RISE);
      slot_full <= slot_full_nxt;
      req_ready <= !slot_full_nxt;
      if (accept) slot <= req_in;
      cyc       <= cyc_nxt;
      rsp_valid <= complete;
      if (complete && cyc.rwb) rsp_rdata <= bus.db_i;

      // Low phase presents address and bank; high phase swaps in write data
      // or releases the data bus for a read. ab/rwb/vpa/vda hold all period.
      if (boundary) begin
        if (state_nxt != S_IDLE) begin
          bus.ab    <= cyc_nxt.addr[15:0];
          bus.db_o  <= cyc_nxt.addr[23:16];
          bus.db_oe <= 1'b1;
          bus.rwb   <= cyc_nxt.rwb;
          bus.vpa   <= cyc_nxt.vpa;
          bus.vda   <= cyc_nxt.vda;
        end else begin
          bus.db_oe <= 1'b0;
          bus.rwb   <= 1'b1;
          bus.vpa   <= 1'b0;
          bus.vda   <= 1'b0;
        end
      end else if (phi2_rise && state != S_IDLE) begin
        if (cyc.rwb) bus.db_oe <= 1'b0;
        else         bus.db_o  <= cyc.wdata;
      end
    end
  end

endmodule

// File: tb/tb_bus65_initiator.sv
// Self-checking bench for bus65_initiator: two parameter variants, directed
// scenarios plus random traffic against a period-level reference model.
module tb_bus65_initiator;

  localparam int LO_A = 2, HI_A = 2;
  localparam int LO_B = 3, HI_B = 1;

  typedef struct packed {
    logic [23:0] addr;
    logic        rwb;
    logic [7:0]  wdata;
    logic        vpa;
    logic        vda;
  } req_t;

  logic clk = 1'b0;
  logic resb = 1'b0;
  always #5 clk = ~clk;

  logic       req_valid [2];
  req_t       req_bits  [2];
  logic       rdy_v     [2];
  logic [7:0] dbi_v     [2];

  logic        req_ready_o [2];
  logic        rsp_valid_o [2];
  logic [7:0]  rsp_rdata_o [2];
  logic        busy_o      [2];
  logic [28:0] pins_obs    [2];

  bus65_initiator_if bus_a ();
  bus65_initiator_if bus_b ();

  assign bus_a.rdy  = rdy_v[0];
  assign bus_a.db_i = dbi_v[0];
  assign bus_b.rdy  = rdy_v[1];
  assign bus_b.db_i = dbi_v[1];
  assign pins_obs[0] = {bus_a.phi2, bus_a.ab, bus_a.db_o, bus_a.db_oe, bus_a.rwb, bus_a.vpa, bus_a.vda};
  assign pins_obs[1] = {bus_b.phi2, bus_b.ab, bus_b.db_o, bus_b.db_oe, bus_b.rwb, bus_b.vpa, bus_b.vda};

  bus65_initiator #(.PHI_LO(LO_A), .PHI_HI(HI_A)) u_a (
    .clk(clk), .resb(resb),
    .req_valid(req_valid[0]), .req_ready(req_ready_o[0]),
    .req_addr(req_bits[0].addr), .req_rwb(req_bits[0].rwb), .req_wdata(req_bits[0].wdata),
    .req_vpa(req_bits[0].vpa), .req_vda(req_bits[0].vda),
    .rsp_valid(rsp_valid_o[0]), .rsp_rdata(rsp_rdata_o[0]), .busy(busy_o[0]),
    .bus(bus_a)
  );

  bus65_initiator #(.PHI_LO(LO_B), .PHI_HI(HI_B)) u_b (
    .clk(clk), .resb(resb),
    .req_valid(req_valid[1]), .req_ready(req_ready_o[1]),
    .req_addr(req_bits[1].addr), .req_rwb(req_bits[1].rwb), .req_wdata(req_bits[1].wdata),
    .req_vpa(req_bits[1].vpa), .req_vda(req_bits[1].vda),
    .rsp_valid(rsp_valid_o[1]), .rsp_rdata(rsp_rdata_o[1]), .busy(busy_o[1]),
    .bus(bus_b)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: one transaction per PHI2 period, pins derived from the
  // transaction and the position inside the period.
  int         m_ph     [2];
  logic       m_phi2   [2];
  logic       m_slot_v [2];
  req_t       m_slot   [2];
  logic       m_cur_v  [2];
  req_t       m_cur    [2];
  logic       m_ready  [2];
  logic       m_rsp_v  [2];
  logic [7:0] m_rdata  [2];
  logic [15:0] m_ab    [2];
  logic [7:0] m_dbo    [2];
  logic       m_oe     [2];
  logic       m_rwb    [2];
  logic       m_vpa    [2];
  logic       m_vda    [2];

  function automatic int lo_of(input int k);
    return (k == 0) ? LO_A : LO_B;
  endfunction

  function automatic int per_of(input int k);
    return (k == 0) ? LO_A + HI_A : LO_B + HI_B;
  endfunction

  function automatic logic [28:0] m_pins(input int k);
    return {m_phi2[k], m_ab[k], m_dbo[k], m_oe[k], m_rwb[k], m_vpa[k], m_vda[k]};
  endfunction

  task automatic model_step(input int k);
    int   p;
    logic acc;
    p = per_of(k);
    if (!resb) begin
      m_ph[k] = 0;      m_phi2[k] = 1'b0;  m_slot_v[k] = 1'b0; m_cur_v[k] = 1'b0;
      m_ready[k] = 1'b0; m_rsp_v[k] = 1'b0; m_rdata[k] = 8'h00;
      m_ab[k] = 16'h0;  m_dbo[k] = 8'h00;  m_oe[k] = 1'b0;
      m_rwb[k] = 1'b1;  m_vpa[k] = 1'b0;   m_vda[k] = 1'b0;
      return;
    end
    acc = req_valid[k] && m_ready[k];
    m_rsp_v[k] = 1'b0;
    if (m_ph[k] == p - 1) begin
      if (!(m_cur_v[k] && !rdy_v[k])) begin
        if (m_cur_v[k]) begin
          m_rsp_v[k] = 1'b1;
          if (m_cur[k].rwb) m_rdata[k] = dbi_v[k];
        end
        m_cur_v[k]  = m_slot_v[k];
        m_cur[k]    = m_slot[k];
        m_slot_v[k] = 1'b0;
      end
    end
    if (acc) begin
      m_slot[k]   = req_bits[k];
      m_slot_v[k] = 1'b1;
    end
    m_ready[k] = !m_slot_v[k];
    m_ph[k]    = (m_ph[k] + 1) % p;
    m_phi2[k]  = (m_ph[k] >= lo_of(k));
    if (m_cur_v[k]) begin
      m_ab[k]  = m_cur[k].addr[15:0];
      m_rwb[k] = m_cur[k].rwb;
      m_vpa[k] = m_cur[k].vpa;
      m_vda[k] = m_cur[k].vda;
      if (!m_phi2[k]) begin
        m_dbo[k] = m_cur[k].addr[23:16];
        m_oe[k]  = 1'b1;
      end else if (!m_cur[k].rwb) begin
        m_dbo[k] = m_cur[k].wdata;
        m_oe[k]  = 1'b1;
      end else begin
        m_oe[k]  = 1'b0;
      end
    end else begin
      m_rwb[k] = 1'b1;
      m_vpa[k] = 1'b0;
      m_vda[k] = 1'b0;
      m_oe[k]  = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  int   cyc_n = 0;
  int   pulse_t [$];
  logic [7:0] pulse_d [$];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Every clock, both instances are compared against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("pins%0d", k), 64'(pins_obs[k]), 64'(m_pins(k)));
      check($sformatf("rsp%0d", k), 64'({rsp_valid_o[k], rsp_rdata_o[k]}), 64'({m_rsp_v[k], m_rdata[k]}));
      check($sformatf("hs%0d", k), 64'({req_ready_o[k], busy_o[k]}), 64'({m_ready[k], m_cur_v[k] || m_slot_v[k]}));
    end
    if (rsp_valid_o[0]) begin
      pulse_t.push_back(cyc_n);
      pulse_d.push_back(rsp_rdata_o[0]);
    end
  end

  task automatic wait_ph(input int k, input int v);
    bit hit = 1'b0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (m_ph[k] == v) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait_ph_reached", 64'(hit), 64'(1));
  endtask

  task automatic issue(input int k, input req_t r);
    bit got = 1'b0;
    req_bits[k]  = r;
    req_valid[k] = 1'b1;
    for (int n = 0; n < 64; n++) begin
      got = m_ready[k];
      @(negedge clk);
      if (got) break;
    end
    req_valid[k] = 1'b0;
    check("issue_accepted", 64'(got), 64'(1));
  endtask

  function automatic req_t mk(input logic [23:0] a, input logic rw, input logic [7:0] wd,
                              input logic vp, input logic vd);
    req_t r;
    r.addr = a; r.rwb = rw; r.wdata = wd; r.vpa = vp; r.vda = vd;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int hi_cnt;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_bits[k]  = '0;
      rdy_v[k]     = 1'b1;
      dbi_v[k]     = 8'h00;
    end

    // Reset values
    @(negedge clk);
    check("rst_pins", 64'(pins_obs[0]), 64'({1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
    check("rst_ready", 64'(req_ready_o[0]), 64'(0));
    check("rst_busy", 64'(busy_o[0]), 64'(0));
    check("rst_rsp", 64'({rsp_valid_o[0], rsp_rdata_o[0]}), 64'(0));
    resb = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(req_ready_o[0]), 64'(1));

    // Write with defaults
    wait_ph(0, 0);
    issue(0, mk(24'h01_1234, 1'b0, 8'hA5, 1'b0, 1'b1));
    wait_ph(0, 0);
    check("wr_lo_ab", 64'(bus_a.ab), 64'(16'h1234));
    check("wr_lo_bank", 64'({bus_a.db_o, bus_a.db_oe, bus_a.rwb}), 64'({8'h01, 1'b1, 1'b0}));
    wait_ph(0, LO_A);
    check("wr_hi_data", 64'({bus_a.db_o, bus_a.db_oe}), 64'({8'hA5, 1'b1}));
    wait_ph(0, 0);
    check("wr_rsp", 64'({rsp_valid_o[0], rsp_rdata_o[0]}), 64'({1'b1, 8'h00}));
    @(negedge clk);
    check("wr_rsp_one_clk", 64'(rsp_valid_o[0]), 64'(0));

    // Read: the value present just before the end-of-period edge is captured
    wait_ph(0, 0);
    issue(0, mk(24'h00_C000, 1'b1, 8'h00, 1'b0, 1'b1));
    wait_ph(0, 0);
    check("rd_lo", 64'({bus_a.ab, bus_a.db_o, bus_a.db_oe, bus_a.rwb}), 64'({16'hC000, 8'h00, 1'b1, 1'b1}));
    wait_ph(0, LO_A);
    check("rd_hi_oe", 64'(bus_a.db_oe), 64'(0));
    dbi_v[0] = 8'h3C;
    wait_ph(0, LO_A + HI_A - 1);
    dbi_v[0] = 8'h5A;
    wait_ph(0, 0);
    check("rd_rsp", 64'({rsp_valid_o[0], rsp_rdata_o[0]}), 64'({1'b1, 8'h5A}));

    // Back-to-back
    dbi_v[0] = 8'h22;
    wait_ph(0, 0);
    pulse_t.delete();
    pulse_d.delete();
    issue(0, mk(24'h00_0010, 1'b0, 8'h11, 1'b0, 1'b1));
    check("b2b_ready_drop", 64'(req_ready_o[0]), 64'(0));
    issue(0, mk(24'h00_0011, 1'b1, 8'h00, 1'b0, 1'b1));
    issue(0, mk(24'h00_0012, 1'b0, 8'h33, 1'b0, 1'b1));
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (pulse_t.size() >= 3) break;
    end
    @(negedge clk);
    check("b2b_pulses", 64'(pulse_t.size()), 64'(3));
    if (pulse_t.size() >= 3) begin
      check("b2b_gap1", 64'(pulse_t[1] - pulse_t[0]), 64'(LO_A + HI_A));
      check("b2b_gap2", 64'(pulse_t[2] - pulse_t[1]), 64'(LO_A + HI_A));
      check("b2b_rdata", 64'({pulse_d[0], pulse_d[1], pulse_d[2]}), 64'({8'h5A, 8'h22, 8'h22}));
    end

    // Wait states: two stalled periods, then completion; queued request waits
    wait_ph(0, 0);
    pulse_t.delete();
    rdy_v[0] = 1'b0;
    issue(0, mk(24'h02_8000, 1'b1, 8'h00, 1'b0, 1'b1));
    wait_ph(0, 0);
    t0 = cyc_n;
    issue(0, mk(24'h00_9000, 1'b0, 8'h44, 1'b0, 1'b1));
    for (int w = 0; w < 2; w++) begin
      wait_ph(0, 0);
      check("ws_hold", 64'({bus_a.ab, bus_a.db_o, bus_a.db_oe}), 64'({16'h8000, 8'h02, 1'b1}));
      check("ws_no_rsp", 64'(rsp_valid_o[0]), 64'(0));
    end
    rdy_v[0] = 1'b1;
    dbi_v[0] = 8'hC3;
    wait_ph(0, 0);
    check("ws_rsp", 64'({rsp_valid_o[0], rsp_rdata_o[0]}), 64'({1'b1, 8'hC3}));
    check("ws_queued_start", 64'(bus_a.ab), 64'(16'h9000));
    @(negedge clk);
    check("ws_one_pulse", 64'(pulse_t.size()), 64'(1));
    if (pulse_t.size() >= 1)
      check("ws_latency", 64'(pulse_t[0] - t0), 64'(3 * (LO_A + HI_A)));
    wait_ph(0, 0);

    // Reset in the middle of a write
    wait_ph(0, 0);
    issue(0, mk(24'h00_0100, 1'b0, 8'h77, 1'b0, 1'b1));
    wait_ph(0, 0);
    wait_ph(0, 1);
    resb = 1'b0;
    @(negedge clk);
    check("mrst_pins", 64'(pins_obs[0]), 64'({1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
    check("mrst_rsp", 64'({rsp_valid_o[0], rsp_rdata_o[0]}), 64'(0));
    check("mrst_hs", 64'({req_ready_o[0], busy_o[0]}), 64'(0));
    resb = 1'b1;
    @(negedge clk);
    check("mrst_release", 64'({req_ready_o[0], bus_a.phi2}), 64'({1'b1, 1'b0}));

    // Variant PHI_LO=3, PHI_HI=1
    wait_ph(1, 0);
    hi_cnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      hi_cnt += int'(bus_b.phi2);
    end
    check("b_duty", 64'(hi_cnt), 64'(1));
    wait_ph(1, 0);
    issue(1, mk(24'h03_4567, 1'b1, 8'h00, 1'b1, 1'b1));
    wait_ph(1, 0);
    check("b_lo", 64'({bus_b.phi2, bus_b.ab, bus_b.db_o}), 64'({1'b0, 16'h4567, 8'h03}));
    wait_ph(1, 3);
    check("b_hi", 64'({bus_b.phi2, bus_b.db_oe}), 64'({1'b1, 1'b0}));
    dbi_v[1] = 8'h96;
    wait_ph(1, 0);
    check("b_rd_rsp", 64'({rsp_valid_o[1], rsp_rdata_o[1]}), 64'({1'b1, 8'h96}));
    wait_ph(1, 3);
    issue(1, mk(24'h00_0200, 1'b0, 8'h5C, 1'b0, 1'b1));
    check("b_defer_idle", 64'({bus_b.db_oe, bus_b.vda, busy_o[1]}), 64'({1'b0, 1'b0, 1'b1}));
    wait_ph(1, 0);
    check("b_defer_start", 64'({bus_b.ab, bus_b.db_oe, bus_b.vda}), 64'({16'h0200, 1'b1, 1'b1}));
    wait_ph(1, 0);

    // Random traffic on both instances, occasional resets
    for (int n = 0; n < 400; n++) begin
      resb = ($urandom_range(0, 149) != 0);
      for (int k = 0; k < 2; k++) begin
        req_valid[k]       = ($urandom_range(0, 2) != 0);
        req_bits[k].addr   = 24'($urandom);
        req_bits[k].rwb    = 1'($urandom);
        req_bits[k].wdata  = 8'($urandom);
        req_bits[k].vpa    = 1'($urandom);
        req_bits[k].vda    = 1'($urandom);
        rdy_v[k]           = ($urandom_range(0, 3) != 0);
        dbi_v[k]           = 8'($urandom);
      end
      @(negedge clk);
    end
    resb = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      rdy_v[k]     = 1'b1;
    end
    repeat (16) @(negedge clk);
    check("drain_idle", 64'({busy_o[0], busy_o[1]}), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
